// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read imem and presents
// words to the decoder under valid/stall. Define FETCH_SKID_EN for the one-entry skid buffer.
module fetch_unit #(
    parameter int unsigned PC_W    = 15,
    parameter int unsigned INST_W  = 20,
    parameter logic [4:0]  HALT_OP = 5'd31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_rd,
    input  logic [INST_W-1:0] imem_data,
    output logic [4:0]        op,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    localparam int unsigned OP_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic                infl_q, infl_d;
    logic [PC_W-1:0]     infl_pc_q, infl_pc_d;
`ifdef FETCH_SKID_EN
    logic                skid_v_q, skid_v_d;
    logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
`endif

    logic accept_c;
    logic halt_hit_c;
    logic redirect_c;
    logic issue_c;
    logic load_c;

    // Handshake decode; halt outranks a same-cycle redirect.
    assign accept_c   = valid_q & ~stall;
    assign halt_hit_c = accept_c & (inst_q[INST_W-1 -: OP_W] == HALT_OP);
    assign redirect_c = valid_q & br_taken & ~halt_hit_c;
    assign issue_c    = (state_q == S_FETCH) & ~stall & ~redirect_c & ~halt_hit_c;
    assign load_c     = ~valid_q | accept_c;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        infl_d     = issue_c;
        infl_pc_d  = fetch_pc_q;
`ifdef FETCH_SKID_EN
        skid_v_d    = skid_v_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
`endif
        if (issue_c) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (halt_hit_c) begin
                    state_d  = S_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
`ifdef FETCH_SKID_EN
                    skid_v_d = 1'b0;
`endif
                end else if (redirect_c) begin
                    fetch_pc_d = br_target;
                    valid_d    = 1'b0;
`ifdef FETCH_SKID_EN
                    skid_v_d   = 1'b0;
`endif
                end else if (load_c) begin
                    // Output slot free: skid word first, then the returning word.
`ifdef FETCH_SKID_EN
                    if (skid_v_q) begin
                        inst_d   = skid_inst_q;
                        pc_d     = skid_pc_q;
                        valid_d  = 1'b1;
                        skid_v_d = 1'b0;
                    end else
`endif
                    if (infl_q) begin
                        inst_d  = imem_data;
                        pc_d    = infl_pc_q;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (infl_q) begin
`ifdef FETCH_SKID_EN
                    skid_v_d    = 1'b1;
                    skid_inst_d = imem_data;
                    skid_pc_d   = infl_pc_q;
`else
                    // Drop the returning word and re-fetch it after the stall.
                    fetch_pc_d = infl_pc_q;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= '0;
            inst_q      <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            infl_q      <= 1'b0;
            infl_pc_q   <= '0;
`ifdef FETCH_SKID_EN
            skid_v_q    <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            infl_q      <= infl_d;
            infl_pc_q   <= infl_pc_d;
`ifdef FETCH_SKID_EN
            skid_v_q    <= skid_v_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
`endif
        end
    end

    // Read strobe follows the issue decision so a stall suppresses it in the same cycle.
    assign imem_rd    = issue_c;
    assign imem_addr  = fetch_pc_q;
    assign op         = inst_q[INST_W-1 -: OP_W];
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing steps followed by randomized stall/branch traffic
// checked against a program-order model of the presented PC stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [14:0] br_target = '0;
    logic [19:0] imem_data = '0;
    logic [14:0] imem_addr;
    logic        imem_rd;
    logic [4:0]  op;
    logic [19:0] inst;
    logic        inst_valid;
    logic [14:0] pc;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;
    bit halt_en = 1'b0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .op         (op),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Memory image: opcode from the address page, low bits carry the address itself.
    function automatic logic [19:0] mem_word(input logic [14:0] a);
        if (halt_en && a == 15'd4) return {5'd31, a};
        return {5'(32'(a >> 8) % 31), a};
    endfunction

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input logic st, input logic sl, input logic br, input logic [14:0] tgt);
        @(posedge clk);
        #1;
        start     = st;
        stall     = sl;
        br_taken  = br;
        br_target = tgt;
        #1;
    endtask

    task automatic chk_present(input string tag, input logic [14:0] p);
        logic [19:0] w;
        w = mem_word(p);
        chk({tag, "_valid"}, 32'(inst_valid), 32'(1));
        chk({tag, "_pc"},    32'(pc),   32'(p));
        chk({tag, "_inst"},  32'(inst), 32'(w));
        chk({tag, "_op"},    32'(op),   32'(w[19:15]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},   32'(imem_addr),  32'(0));
        chk({tag, "_rd"},     32'(imem_rd),    32'(0));
        chk({tag, "_op"},     32'(op),         32'(0));
        chk({tag, "_inst"},   32'(inst),       32'(0));
        chk({tag, "_valid"},  32'(inst_valid), 32'(0));
        chk({tag, "_pc"},     32'(pc),         32'(0));
        chk({tag, "_halted"}, 32'(halted),     32'(0));
    endtask

    initial begin
        logic [14:0] exp_pc;
        int          idle;
        logic        s;
        logic        b;
        logic [14:0] tgt;

        // Reset state
        rst_n = 1'b0;
        step(0, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        chk_all_zero("rst");

        // Start latency and streaming
        rst_n = 1'b1;
        step(1, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        chk("lat1_rd",    32'(imem_rd),    32'(1));
        chk("lat1_addr",  32'(imem_addr),  32'(0));
        chk("lat1_valid", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk("lat2_valid", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk_present("p0", 15'd0);
        step(0, 0, 0, 15'd0);
        chk_present("p1", 15'd1);

        // Stall three cycles on pc 2
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 15'd0);
            chk_present("stall_p2", 15'd2);
            chk("stall_rd", 32'(imem_rd), 32'(0));
        end
        step(0, 0, 0, 15'd0);
        chk_present("rel_p2", 15'd2);
`ifdef FETCH_SKID_EN
        step(0, 0, 0, 15'd0);
        chk_present("rel_p3", 15'd3);
`else
        step(0, 0, 0, 15'd0);
        chk("rel_bubble", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk_present("rel_p3", 15'd3);
`endif
        step(0, 0, 0, 15'd0);
        chk_present("rel_p4", 15'd4);

        // Branch to 0x0100 while pc 5 presented
        step(0, 0, 1, 15'h0100);
        chk_present("br_p5", 15'd5);
        step(0, 0, 0, 15'd0);
        chk("br_b1", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk("br_b2", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk_present("br_tgt", 15'h0100);

        // Branch near the top of the address space and wrap
        step(0, 0, 1, 15'h7FFE);
        chk_present("br_p101", 15'h0101);
        step(0, 0, 0, 15'd0);
        chk("wr_b1", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk("wr_b2", 32'(inst_valid), 32'(0));
        step(0, 0, 0, 15'd0);
        chk_present("wr_7ffe", 15'h7FFE);
        halt_en = 1'b1;
        step(0, 0, 0, 15'd0);
        chk_present("wr_7fff", 15'h7FFF);
        step(0, 0, 0, 15'd0);
        chk_present("wr_0000", 15'h0000);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 15'd0);
            chk_present("wr_seq", 15'(i));
        end

        // Halt word at address 4, with a same-cycle branch that must lose
        step(0, 0, 1, 15'h0200);
        chk_present("halt_p4", 15'd4);
        chk("halt_rd_acc", 32'(imem_rd), 32'(0));
        step(0, 0, 0, 15'd0);
        chk("halt_flag",  32'(halted),     32'(1));
        chk("halt_valid", 32'(inst_valid), 32'(0));
        for (int i = 0; i < 10; i++) begin
            step(logic'(i % 2 == 0), 0, 0, 15'd0);
            chk("halt_hold_rd",    32'(imem_rd),    32'(0));
            chk("halt_hold_flag",  32'(halted),     32'(1));
            chk("halt_hold_valid", 32'(inst_valid), 32'(0));
        end
        halt_en = 1'b0;

        // Reset mid-stream with a word in flight under stall
        rst_n = 1'b0;
        step(0, 0, 0, 15'd0);
        rst_n = 1'b1;
        step(1, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        chk_present("rs_p0", 15'd0);
        step(0, 0, 0, 15'd0);
        chk_present("rs_p1", 15'd1);
        step(0, 1, 0, 15'd0);
        chk_present("rs_p2", 15'd2);
        rst_n = 1'b0;
        step(0, 1, 0, 15'd0);
        rst_n = 1'b1;
        chk_all_zero("midrst");
        step(0, 0, 0, 15'd0);
        chk("idle_rd", 32'(imem_rd), 32'(0));
        step(1, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        chk("re_rd",   32'(imem_rd),   32'(1));
        chk("re_addr", 32'(imem_addr), 32'(0));
        step(0, 0, 0, 15'd0);
        step(0, 0, 0, 15'd0);
        chk_present("re_p0", 15'd0);

        // Random stall/branch traffic; pc 0 above is accepted at the next edge
        exp_pc = 15'd1;
        idle   = 0;
        for (int k = 0; k < 1500; k++) begin
            s   = ($urandom_range(0, 2) == 0);
            b   = ($urandom_range(0, 7) == 0);
            tgt = 15'($urandom);
            step(0, s, b, tgt);
            chk("rnd_halted", 32'(halted), 32'(0));
            if (s) chk("rnd_stall_rd", 32'(imem_rd), 32'(0));
            if (inst_valid === 1'b1) begin
                chk_present("rnd", exp_pc);
                idle = 0;
                if (b) exp_pc = tgt;
                else if (!s) exp_pc = exp_pc + 15'd1;
            end else begin
                if (!s) idle++;
                chk("rnd_progress", 32'(idle > 4), 32'(0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
